// File: rtl/generador_pwm_servos.sv
// Four-channel hobby-servo PWM generator sharing one period counter; angles latch at period boundaries.
// Optional: define SERVO_SLEW_EN to limit each shadow angle to a bounded step per period.
module generador_pwm_servos #(
  parameter int CICLOS_US      = 50,
  parameter int PERIODO_US     = 20000,
  parameter int PULSO_MIN_US   = 500,
  parameter int PASO_US        = 10,
  parameter int ANGULO_MAX     = 180,
  parameter int ANGULO_INICIAL = 90
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       habilitar,
  input  logic [7:0] angulo_servo_1,
  input  logic [7:0] angulo_servo_2,
  input  logic [7:0] angulo_servo_3,
  input  logic [7:0] angulo_servo_4,
  output logic [3:0] pwm,
  output logic       inicio_periodo,
  output logic       activo
);

  localparam int CW = $clog2(PERIODO_US);
  localparam int PW = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;
  localparam logic [7:0] ANG_MAX = 8'(ANGULO_MAX);
  localparam logic [7:0] ANG_INI = 8'(ANGULO_INICIAL);

  typedef enum logic {APAGADO, ACTIVO} estado_t;

  estado_t       estado_reg;
  logic [PW-1:0] presc_reg;
  logic [CW-1:0] cont_us_reg;
  logic          inicio_reg;
  logic          activo_reg;
  logic          tick_us;
  logic          fin_periodo;
  logic          cargar;
  logic [7:0]    angulo_in [4];

  assign angulo_in[0] = angulo_servo_1;
  assign angulo_in[1] = angulo_servo_2;
  assign angulo_in[2] = angulo_servo_3;
  assign angulo_in[3] = angulo_servo_4;

  assign tick_us     = (estado_reg == ACTIVO) && (presc_reg == PW'(CICLOS_US - 1));
  assign fin_periodo = tick_us && (cont_us_reg == CW'(PERIODO_US - 1));
  // Shadows change only where a new period begins, so a pulse is never cut or stretched.
  assign cargar      = fin_periodo || ((estado_reg == APAGADO) && habilitar);

  assign inicio_periodo = inicio_reg;
  assign activo         = activo_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg  <= APAGADO;
      presc_reg   <= '0;
      cont_us_reg <= '0;
      inicio_reg  <= 1'b0;
      activo_reg  <= 1'b0;
    end else begin
      case (estado_reg)
        APAGADO: begin
          presc_reg   <= '0;
          cont_us_reg <= '0;
          inicio_reg  <= habilitar;
          activo_reg  <= habilitar;
          if (habilitar) estado_reg <= ACTIVO;
        end
        ACTIVO: begin
          presc_reg <= tick_us ? '0 : presc_reg + 1'b1;
          if (fin_periodo)  cont_us_reg <= '0;
          else if (tick_us) cont_us_reg <= cont_us_reg + 1'b1;
          inicio_reg <= fin_periodo && habilitar;
          activo_reg <= !(fin_periodo && !habilitar);
          if (fin_periodo && !habilitar) estado_reg <= APAGADO;
        end
        default: estado_reg <= APAGADO;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_canal
      logic [7:0]  objetivo;
      logic [7:0]  sombra_reg;
      logic [7:0]  sombra_next;
      logic [15:0] ancho_us;
      logic        pwm_reg;

      assign objetivo = (angulo_in[gi] > ANG_MAX) ? ANG_MAX : angulo_in[gi];

`ifdef SERVO_SLEW_EN
      localparam logic [7:0] SLEW_GRADOS = 8'd2;
      always_comb begin
        sombra_next = objetivo;
        if (objetivo > sombra_reg) begin
          if (objetivo - sombra_reg > SLEW_GRADOS) sombra_next = sombra_reg + SLEW_GRADOS;
        end else if (sombra_reg - objetivo > SLEW_GRADOS) begin
          sombra_next = sombra_reg - SLEW_GRADOS;
        end
      end
`else
      always_comb begin
        sombra_next = objetivo;
      end
`endif

      assign ancho_us = 16'(PULSO_MIN_US) + 16'(sombra_reg) * 16'(PASO_US);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sombra_reg <= ANG_INI;
          pwm_reg    <= 1'b0;
        end else begin
          if (cargar) sombra_reg <= sombra_next;
          pwm_reg <= (estado_reg == ACTIVO) && (16'(cont_us_reg) < ancho_us);
        end
      end

      assign pwm[gi] = pwm_reg;
    end
  endgenerate

endmodule
